// File: rtl/serial_pair_pkg.sv
// Shared types and limits for the serial pair serializer.
// cnt_width() clamps WIDTH into the legal range before sizing the beat counter.
package serial_pair_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sp_state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned c;
        c = w;
        if (c < WIDTH_MIN) begin
            c = WIDTH_MIN;
        end
        if (c > WIDTH_MAX) begin
            c = WIDTH_MAX;
        end
        return $clog2(c);
    endfunction

endpackage

// File: rtl/serial_pair_shift_reg.sv
// Two WIDTH-bit load/shift-left registers; the MSBs are the current serial bits.
// Load has priority over shift; no handshake of its own, the parent decides when to move.
import serial_pair_pkg::*;

module serial_pair_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             msb_a_o,
    output logic             msb_b_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = a_i;
            b_d = b_i;
        end else if (shift_i) begin
            a_d = {a_q[WIDTH-2:0], 1'b0};
            b_d = {b_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign msb_a_o = a_q[WIDTH-1];
    assign msb_b_o = b_q[WIDTH-1];

endmodule

// File: rtl/serial_pair_serializer_msb_first.sv
// Serializes an in_a/in_b pair MSB first, one bit pair per out handshake, 1-cycle latency.
// Holds outputs under out_ready=0; SERIAL_PAIR_SERIALIZER_SKID_EN adds a one-entry pending frame.
import serial_pair_pkg::*;

module serial_pair_serializer_msb_first #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

    sp_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             beat_fire;
    logic             last_fire;
    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic             msb_a;
    logic             msb_b;

`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
    logic             pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] pend_a_q, pend_a_d;
    logic [WIDTH-1:0] pend_b_q, pend_b_d;

    assign in_ready = !pend_vld_q;
`else
    assign in_ready = (state_q == ST_IDLE);
`endif

    assign accept    = in_valid && in_ready;
    assign beat_fire = (state_q == ST_SHIFT) && out_ready;
    assign last_fire = beat_fire && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        load_a   = in_a;
        load_b   = in_b;
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
        pend_vld_d = pend_vld_q;
        pend_a_d   = pend_a_q;
        pend_b_d   = pend_b_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sr_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_fire) begin
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
                    // Next frame comes from the buffer, or straight from the input when it lands now.
                    if (pend_vld_q) begin
                        load_a     = pend_a_q;
                        load_b     = pend_b_q;
                        sr_load    = 1'b1;
                        cnt_d      = '0;
                        pend_vld_d = 1'b0;
                    end else if (accept) begin
                        sr_load = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else if (beat_fire) begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
                if (accept && !last_fire) begin
                    pend_vld_d = 1'b1;
                    pend_a_d   = in_a;
                    pend_b_d   = in_b;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_a_q   <= '0;
            pend_b_q   <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
        end
    end
`endif

    serial_pair_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .a_i     (load_a),
        .b_i     (load_b),
        .msb_a_o (msb_a),
        .msb_b_o (msb_b)
    );

    // Outputs are masked in IDLE so stale shift contents never leak.
    assign out_valid = (state_q == ST_SHIFT);
    assign out_a     = out_valid && msb_a;
    assign out_b     = out_valid && msb_b;
    assign out_first = out_valid && (cnt_q == '0);
    assign out_last  = out_valid && (cnt_q == LAST_BEAT);

endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// Directed bench for serial_pair_serializer_msb_first at WIDTH=8.
module tb_serial_pair_serializer_msb_first;

`ifdef SERIAL_PAIR_SERIALIZER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic       out_a;
    logic       out_b;
    logic       out_first;
    logic       out_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_pair_serializer_msb_first #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_first (out_first),
        .out_last  (out_last)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {valid, first, last, a, b} for beat i of a frame ea/eb
    task automatic check_beat(input string tag, input int i, input logic [7:0] ea, input logic [7:0] eb);
        chk(tag, {27'd0, out_valid, out_first, out_last, out_a, out_b},
            {27'd0, 1'b1, (i == 0), (i == 7), ea[7-i], eb[7-i]});
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        chk("offer_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
    endtask

    task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b, input int exp_res);
        int  res;
        bit  decided;
        bit  seen_last;
        res       = 0;
        decided   = 1'b0;
        seen_last = 1'b0;
        offer(a, b);
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_ready) begin
                if (!decided && (out_a != out_b)) begin
                    res     = out_a ? 2 : 1;
                    decided = 1'b1;
                end
                if (out_last) begin
                    seen_last = 1'b1;
                    chk(tag, res, exp_res);
                end
            end
            tick();
        end
        chk({tag, "_last_seen"}, {31'd0, seen_last}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int        last1;
        int        first2;
        int        nacc;
        int        nbits;
        logic      vld_after;
        logic      acc;
        logic [7:0] got_a;
        logic [7:0] got_b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_state", {26'd0, in_ready, out_valid, out_first, out_last, out_a, out_b}, 32'b100000);

        // Basic A5/3C frame, continuous out_ready
        offer(8'hA5, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            check_beat("basic_beat", i, 8'b1010_0101, 8'b0011_1100);
            if (i == 3) begin
                chk("busy_in_ready", {31'd0, in_ready}, {31'd0, SKID});
            end
            tick();
        end
        chk("basic_idle_after", {31'd0, out_valid}, 32'd0);

        // Stall three cycles at beat 2
        offer(8'hA5, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            check_beat("stall_beat", i, 8'b1010_0101, 8'b0011_1100);
            if (i == 2) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check_beat("stall_hold", 2, 8'b1010_0101, 8'b0011_1100);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("stall_idle_after", {31'd0, out_valid}, 32'd0);

        // Two frames offered back to back
        last1     = -1;
        first2    = -1;
        nacc      = 0;
        nbits     = 0;
        vld_after = 1'bx;
        got_a     = 8'h00;
        got_b     = 8'h00;
        in_valid  = 1'b1;
        in_a      = 8'h81;
        in_b      = 8'h7E;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_last && last1 < 0) begin
                last1 = c;
            end else if (out_valid && out_first && last1 >= 0 && first2 < 0) begin
                first2 = c;
            end
            if (last1 >= 0 && c == last1 + 1) begin
                vld_after = out_valid;
            end
            if (first2 >= 0 && out_valid && out_ready && nbits < 8) begin
                got_a = {got_a[6:0], out_a};
                got_b = {got_b[6:0], out_b};
                nbits++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    in_a = 8'h5A;
                    in_b = 8'hC3;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_gap", first2 - last1, SKID ? 32'd1 : 32'd2);
        chk("b2b_valid_after_last", {31'd0, vld_after}, {31'd0, SKID});
        chk("b2b_frame2_a", {24'd0, got_a}, 32'h5A);
        chk("b2b_frame2_b", {24'd0, got_b}, 32'hC3);

        // Reset at beat 4, with a pending frame offered during beat 1
        offer(8'hA5, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            check_beat("prerst_beat", i, 8'b1010_0101, 8'b0011_1100);
            if (i == 1) begin
                in_valid = 1'b1;
                in_a     = 8'h11;
                in_b     = 8'h22;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check_beat("prerst_beat", 4, 8'b1010_0101, 8'b0011_1100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_outputs", {26'd0, in_ready, out_valid, out_first, out_last, out_a, out_b}, 32'b100000);
        tick();
        chk("midrst_no_resume1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("midrst_no_resume2", {31'd0, out_valid}, 32'd0);
        offer(8'hFF, 8'h00);
        for (int i = 0; i < 8; i++) begin
            check_beat("postrst_beat", i, 8'hFF, 8'h00);
            tick();
        end

        // Serial comparator fed from the outputs: 0=eq, 1=a<b, 2=a>b
        run_cmp("cmp_5_9", 8'd5, 8'd9, 1);
        run_cmp("cmp_9_5", 8'd9, 8'd5, 2);
        run_cmp("cmp_7_7", 8'd7, 8'd7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_pair_serializer_msb_first.md
SERIAL_PAIR_SERIALIZER_MSB_FIRST -- requirements
Module: serial_pair_serializer_msb_first

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit count of each parallel operand; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the in_a/in_b pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts the offered pair this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, WIDTH each, the parallel operands.
REQ-007 The block SHALL have port out_valid, output, 1, meaning out_a/out_b carry a valid bit pair.
REQ-008 The block SHALL have port out_ready, input, 1, the downstream acceptance of the current bit pair.
REQ-009 The block SHALL have ports out_a and out_b, output, 1 each, the serial bits of in_a and in_b, MSB first.
REQ-010 The block SHALL have ports out_first and out_last, output, 1 each, marking the MSB beat and the LSB beat of a frame.

Function
REQ-011 The block SHALL accept a pair on any rising edge where in_valid and in_ready are both 1, and SHALL capture in_a and in_b as the frame.
REQ-012 The block SHALL implement states IDLE and SHIFT: IDLE goes to SHIFT on accept; SHIFT goes to IDLE when the LSB beat is consumed and no frame is pending.
REQ-013 The block SHALL present the MSB beat with out_valid=1 and out_first=1 in the cycle after accept, giving a latency of 1 cycle.
REQ-014 The block SHALL advance one bit per rising edge where out_valid and out_ready are both 1, using a beat counter of $clog2(WIDTH) bits.
REQ-015 The block SHALL hold out_a, out_b, out_first and out_last stable while out_valid=1 and out_ready=0.
REQ-016 The block SHALL assert out_last only on beat WIDTH-1 (the LSB), and out_first only on beat 0.
REQ-017 The block SHALL drive out_valid=0, out_first=0 and out_last=0 in IDLE; out_a and out_b SHALL be 0 in IDLE.
REQ-018 The block SHALL generate in_ready only from registered state, with no combinational path from out_ready or in_valid.
REQ-019 The block SHALL ignore in_a and in_b in every cycle where no accept occurs.

Reset
REQ-020 The block SHALL, when rst_n=0 at a rising edge, enter IDLE, clear the counter, shift registers and pending buffer, and drive in_ready=1 and all out_* outputs to 0 in the following cycle.
REQ-021 The block SHALL discard any in-progress or pending frame when reset occurs mid-frame; no partial frame resumes after reset.

Configuration
REQ-022 The block SHALL use macro SERIAL_PAIR_SERIALIZER_SKID_EN to compile in the pending-frame buffer.
REQ-023 The block SHALL, without the macro, drive in_ready=1 only in IDLE, so back-to-back frames have a gap of at least one cycle with out_valid=0.
REQ-024 The block SHALL, with the macro, drive in_ready=1 whenever the one-entry pending buffer is empty, including during SHIFT.
REQ-025 The block SHALL, with the macro, start a pending frame's MSB beat in the cycle after its previous frame's LSB beat is consumed, giving zero gap.

Structure
REQ-026 The block SHALL take its state enum type and constant WIDTH_MAX=32 from package serial_pair_pkg.
REQ-027 The block SHALL contain one sub-module, serial_pair_shift_reg: a WIDTH-bit load/shift-left register pair exposing the current MSB bits.

Verification
REQ-028 The bench SHALL check: WIDTH=8, in_a=8'hA5, in_b=8'h3C, out_ready=1 -> out_a=1,0,1,0,0,1,0,1 and out_b=0,0,1,1,1,1,0,0 on 8 consecutive cycles starting one cycle after accept, with out_first on beat 0 and out_last on beat 7.
REQ-029 The bench SHALL check: out_ready=0 for 3 cycles at beat 2 of A5/3C -> outputs frozen at beat 2 values (out_a=1, out_b=1) for those 3 cycles, then continue unchanged.
REQ-030 The bench SHALL check: two frames offered continuously -> without the macro, one out_valid=0 cycle appears between the frames; with the macro, the second out_first follows the first out_last with no gap.
REQ-031 The bench SHALL check: rst_n=0 at beat 4 -> all outputs 0 and in_ready=1 next cycle; a new frame 8'hFF/8'h00 then serializes from its MSB.
REQ-032 The bench SHALL check: outputs fed to a MSB-first serial comparator with pairs 5/9, 9/5 and 7/7 -> a_less_b, a_greater_b and a_eq_b respectively on the out_last beat.
